// File: rtl/kf76489_seq_pkg.sv
// rtl/kf76489_seq_pkg.sv - shared types, constants and byte encoders for the KF76489 write sequencer
// Contents: seq_state_t (IDLE/STROBE/GAP), tone register addresses,
//           HOLD_CYCLES_DEFAULT, bit_rev8, is_two_byte, enc_first_byte, enc_second_byte.
package kf76489_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_GAP    = 2'd2
   } seq_state_t;

   localparam int HOLD_CYCLES_DEFAULT = 64;

   // Tone-frequency registers carry a 10-bit value and need a second byte.
   localparam logic [2:0] ADDR_TONE0 = 3'd0;
   localparam logic [2:0] ADDR_TONE1 = 3'd2;
   localparam logic [2:0] ADDR_TONE2 = 3'd4;

   // The chip's D0 pin is the MSB of its internal latch, so bytes go out bit-reversed.
   function automatic logic [7:0] bit_rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = b[7 - i];
      end
      return r;
   endfunction

   function automatic logic is_two_byte(input logic [2:0] addr);
      return (addr == ADDR_TONE0) || (addr == ADDR_TONE1) || (addr == ADDR_TONE2);
   endfunction

   // Latch byte: marker bit, register address, low data nibble.
   function automatic logic [7:0] enc_first_byte(input logic [2:0] addr, input logic [3:0] lo);
      return bit_rev8({1'b1, addr, lo});
   endfunction

   // Data byte: upper six bits of a tone value.
   function automatic logic [7:0] enc_second_byte(input logic [5:0] hi);
      return bit_rev8({2'b00, hi});
   endfunction

endpackage

// File: rtl/kf76489_seq_arbiter.sv
// rtl/kf76489_seq_arbiter.sv - two-way round-robin grant for the KF76489 write sequencer
// Ports: clock, reset_n (async, active low); req_valid[1:0] requests;
//        take = the sequencer accepts the current grant; grant[1:0] one-hot winner (combinational).
module kf76489_seq_arbiter (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] req_valid,
   input  logic       take,
   output logic [1:0] grant
);

   // Set when requester 1 should win the next tie.
   logic favour_1;

   always_comb begin
      grant = req_valid;
      if (req_valid == 2'b11) begin
         grant = favour_1 ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         favour_1 <= 1'b0;
      end else if (take) begin
         favour_1 <= grant[0];
      end
   end

endmodule

// File: rtl/kf76489_write_sequencer.sv
// rtl/kf76489_write_sequencer.sv - arbitrates two register writers and strobes bytes into a KF76489
// Ports: clock, reset_n (async, active low);
//        req_valid[1:0], req_ready[1:0] (one-cycle accept pulse), req_addr[5:0] (2x3), req_data[19:0] (2x10);
//        READY chip ready; CE_N, WE_N active-low strobes; D_OUT[7:0] byte to chip; busy = not IDLE.
// Option: KF76489_SEQ_SHADOW_EN keeps a shadow of written registers and skips rewrites of equal values.
import kf76489_seq_pkg::*;

module kf76489_write_sequencer #(
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [5:0]  req_addr,
   input  logic [19:0] req_data,
   input  logic        READY,
   output logic        CE_N,
   output logic        WE_N,
   output logic [7:0]  D_OUT,
   output logic        busy
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   seq_state_t       state;
   logic [CNT_W-1:0] hold_cnt;
   logic [2:0]       cap_addr;
   logic [9:0]       cap_data;
   logic             second_pending;
   logic [1:0]       grant;
   logic             take;
   logic [2:0]       sel_addr;
   logic [9:0]       sel_data;
   logic             strobe_done;
   logic             hit_q;

   // No grant in the pulse cycle itself: the requester still shows valid until it sees req_ready.
   assign take        = (state == ST_IDLE) && (req_ready == 2'b00) && (req_valid != 2'b00);
   assign sel_addr    = grant[1] ? req_addr[5:3]   : req_addr[2:0];
   assign sel_data    = grant[1] ? req_data[19:10] : req_data[9:0];
   assign strobe_done = (state == ST_STROBE) && (hold_cnt >= HOLD_LAST) && READY;

   kf76489_seq_arbiter u_arb (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .take      (take),
      .grant     (grant)
   );

`ifdef KF76489_SEQ_SHADOW_EN
   logic [9:0] shadow_data [8];
   logic [7:0] shadow_vld;
   logic       last_done;

   assign last_done = strobe_done && !second_pending;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shadow_vld <= '0;
         hit_q      <= 1'b0;
      end else begin
         if (take) begin
            hit_q <= shadow_vld[sel_addr] && (shadow_data[sel_addr] == sel_data);
         end
         if (last_done) begin
            shadow_vld[cap_addr] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (last_done) begin
         shadow_data[cap_addr] <= cap_data;
      end
   end
`else
   assign hit_q = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         req_ready      <= 2'b00;
         CE_N           <= 1'b1;
         WE_N           <= 1'b1;
         D_OUT          <= 8'hFF;
         busy           <= 1'b0;
         hold_cnt       <= '0;
         cap_addr       <= '0;
         cap_data       <= '0;
         second_pending <= 1'b0;
      end else begin
         req_ready <= 2'b00;
         case (state)
            ST_IDLE: begin
               if (req_ready != 2'b00) begin
                  // Cycle after the accept pulse: start the first byte unless the shadow says it is redundant.
                  if (!hit_q) begin
                     state          <= ST_STROBE;
                     CE_N           <= 1'b0;
                     WE_N           <= 1'b0;
                     D_OUT          <= enc_first_byte(cap_addr, cap_data[3:0]);
                     busy           <= 1'b1;
                     hold_cnt       <= '0;
                     second_pending <= is_two_byte(cap_addr);
                  end
               end else if (take) begin
                  req_ready <= grant;
                  cap_addr  <= sel_addr;
                  cap_data  <= sel_data;
               end
            end
            ST_STROBE: begin
               if (strobe_done) begin
                  state <= ST_GAP;
                  CE_N  <= 1'b1;
                  WE_N  <= 1'b1;
               end else if (hold_cnt < HOLD_LAST) begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (second_pending) begin
                  state          <= ST_STROBE;
                  CE_N           <= 1'b0;
                  WE_N           <= 1'b0;
                  D_OUT          <= enc_second_byte(cap_data[9:4]);
                  hold_cnt       <= '0;
                  second_pending <= 1'b0;
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kf76489_write_sequencer.sv
// tb/tb_kf76489_write_sequencer.sv - self-checking bench for kf76489_write_sequencer
module tb_kf76489_write_sequencer;

   localparam int HOLD = 64;

   typedef struct packed {
      logic [2:0] a;
      logic [9:0] d;
   } req_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [5:0]  req_addr;
   logic [19:0] req_data;
   logic        READY = 1'b1;
   logic        CE_N;
   logic        WE_N;
   logic [7:0]  D_OUT;
   logic        busy;

   int errors = 0;
   int checks = 0;

   req_t q0[$];
   req_t q1[$];
   int   runs[$];
   int   run_bytes[$];
   int   grants[$];
   int   run = 0;

   logic [1:0] exp_ready = 2'b00;
   logic       exp_ce = 1'b1;
   logic       exp_we = 1'b1;
   logic       exp_busy = 1'b0;
   logic [7:0] exp_dout = 8'hFF;
   bit         m_fav1 = 1'b0;
`ifdef KF76489_SEQ_SHADOW_EN
   bit         sh_v[8];
   int         sh_d[8];
`endif

   kf76489_write_sequencer #(.HOLD_CYCLES(HOLD)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .READY     (READY),
      .CE_N      (CE_N),
      .WE_N      (WE_N),
      .D_OUT     (D_OUT),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] rev8(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 8; i++) r = r * 2 + ((v >> i) & 1);
      return 8'(r);
   endfunction

   task automatic check_int(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, want);
      end
   endtask

   task automatic model_reset();
      exp_ready = 2'b00;
      exp_ce    = 1'b1;
      exp_we    = 1'b1;
      exp_busy  = 1'b0;
      exp_dout  = 8'hFF;
      m_fav1    = 1'b0;
`ifdef KF76489_SEQ_SHADOW_EN
      for (int i = 0; i < 8; i++) sh_v[i] = 1'b0;
`endif
   endtask

   // Transaction-level model: each write is a pulse, one idle-to-strobe cycle,
   // then per byte at least HOLD low cycles ending on READY, then one gap cycle.
   initial begin : model_proc
      int g, a, d, done, nb;
      bit ab, hit;
      logic [7:0] bl[$];
      forever begin
         @(posedge clock);
         if (!reset_n) begin model_reset(); continue; end
         exp_ready = 2'b00;
         if (req_valid == 2'b00) continue;
         if (req_valid == 2'b11) g = m_fav1 ? 1 : 0;
         else g = req_valid[1] ? 1 : 0;
         m_fav1 = (g == 0);
         a = (g == 1) ? int'(req_addr[5:3]) : int'(req_addr[2:0]);
         d = (g == 1) ? int'(req_data[19:10]) : int'(req_data[9:0]);
         exp_ready = (g == 1) ? 2'b10 : 2'b01;
         @(posedge clock);
         if (!reset_n) begin model_reset(); continue; end
         exp_ready = 2'b00;
         hit = 1'b0;
`ifdef KF76489_SEQ_SHADOW_EN
         hit = sh_v[a] && (sh_d[a] == d);
`endif
         if (hit) continue;
         bl.delete();
         bl.push_back(rev8(128 + a * 16 + d % 16));
         if (a == 0 || a == 2 || a == 4) bl.push_back(rev8(d / 16));
         nb = bl.size();
         ab = 1'b0;
         for (int k = 0; k < nb; k++) begin
            exp_ce = 1'b0; exp_we = 1'b0; exp_busy = 1'b1; exp_dout = bl[k];
            done = 0;
            forever begin
               @(posedge clock);
               if (!reset_n) begin ab = 1'b1; break; end
               done++;
               if (done >= HOLD && READY) break;
            end
            if (ab) break;
            exp_ce = 1'b1; exp_we = 1'b1;
`ifdef KF76489_SEQ_SHADOW_EN
            if (k == nb - 1) begin sh_v[a] = 1'b1; sh_d[a] = d; end
`endif
            @(posedge clock);
            if (!reset_n) begin ab = 1'b1; break; end
         end
         if (ab) model_reset();
         else exp_busy = 1'b0;
      end
   end

   // Requesters: hold the queue head until its accept pulse is seen.
   initial begin : driver
      logic [1:0] seen;
      req_t tmp;
      req_valid = 2'b00;
      req_addr  = '0;
      req_data  = '0;
      forever begin
         @(negedge clock);
         seen = req_ready;
         @(posedge clock);
         #1;
         if (seen[0] && req_valid[0] && q0.size() > 0) tmp = q0.pop_front();
         if (seen[1] && req_valid[1] && q1.size() > 0) tmp = q1.pop_front();
         if (q0.size() > 0) begin
            req_valid[0] = 1'b1; req_addr[2:0] = q0[0].a; req_data[9:0] = q0[0].d;
         end else req_valid[0] = 1'b0;
         if (q1.size() > 0) begin
            req_valid[1] = 1'b1; req_addr[5:3] = q1[0].a; req_data[19:10] = q1[0].d;
         end else req_valid[1] = 1'b0;
      end
   end

   // Per-cycle comparison plus recording of strobe runs and grants.
   always @(negedge clock) begin : chk
      logic [12:0] act, want;
      act = {req_ready, CE_N, WE_N, D_OUT, busy};
      if (!reset_n) want = {2'b00, 1'b1, 1'b1, 8'hFF, 1'b0};
      else want = {exp_ready, exp_ce, exp_we, exp_dout, exp_busy};
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s t=%0t got ready=%b ce=%b we=%b dout=%h busy=%b expected ready=%b ce=%b we=%b dout=%h busy=%b",
                  reset_n ? "cycle" : "reset", $time, act[12:11], act[10], act[9], act[8:1], act[0],
                  want[12:11], want[10], want[9], want[8:1], want[0]);
      end
      if (CE_N === 1'b0) begin
         if (run == 0) run_bytes.push_back(int'(D_OUT));
         run++;
      end else if (run > 0) begin
         runs.push_back(run);
         run = 0;
      end
      if (req_ready[0] === 1'b1) grants.push_back(0);
      if (req_ready[1] === 1'b1) grants.push_back(1);
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic push(input int r, input int a, input int d);
      req_t t;
      t.a = 3'(a);
      t.d = 10'(d);
      if (r == 0) q0.push_back(t);
      else q1.push_back(t);
   endtask

   task automatic clear_logs();
      runs.delete();
      run_bytes.delete();
      grants.delete();
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!(q0.size() == 0 && q1.size() == 0 && req_valid == 2'b00 && exp_busy == 1'b0 &&
                   exp_ready == 2'b00 && busy == 1'b0) && n < budget);
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_timeout: still busy after %0d cycles", name, n);
      end
      cycles(3);
   endtask

   task automatic do_reset();
      @(posedge clock);
      #3 reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #3 reset_n = 1'b1;
      cycles(2);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      reset_n = 1'b0;
      READY   = 1'b1;
      repeat (4) @(posedge clock);
      #2 reset_n = 1'b1;
      cycles(2);

      // Tone write: two bytes of 64 low cycles each.
      clear_logs();
      push(0, 0, 10);
      wait_idle(500, "s1");
      check_int("s1_runs", runs.size(), 2);
      check_int("s1_len0", runs.size() > 0 ? runs[0] : -1, 64);
      check_int("s1_len1", runs.size() > 1 ? runs[1] : -1, 64);
      check_int("s1_byte0", run_bytes.size() > 0 ? run_bytes[0] : -1, 'h51);
      check_int("s1_byte1", run_bytes.size() > 1 ? run_bytes[1] : -1, 'h00);

      // Queued writes: one-byte, tone, one-byte with ignored upper data.
      clear_logs();
      push(0, 1, 0);
      push(0, 2, 32);
      push(0, 6, 'h3FF);
      wait_idle(900, "s2");
      check_int("s2_runs", runs.size(), 4);
      check_int("s2_byte0", run_bytes.size() > 0 ? run_bytes[0] : -1, 'h09);
      check_int("s2_byte1", run_bytes.size() > 1 ? run_bytes[1] : -1, 'h05);
      check_int("s2_byte2", run_bytes.size() > 2 ? run_bytes[2] : -1, 'h40);
      check_int("s2_byte3", run_bytes.size() > 3 ? run_bytes[3] : -1, 'hF7);

      // Round robin from reset: tie -> 0, then 1 wins the next tie, then 0.
      do_reset();
      clear_logs();
      push(0, 3, 1);
      push(0, 6, 'h155);
      push(1, 5, 7);
      wait_idle(900, "s3");
      check_int("s3_grants", grants.size(), 3);
      check_int("s3_grant0", grants.size() > 0 ? grants[0] : -1, 0);
      check_int("s3_grant1", grants.size() > 1 ? grants[1] : -1, 1);
      check_int("s3_grant2", grants.size() > 2 ? grants[2] : -1, 0);
      check_int("s3_byte0", run_bytes.size() > 0 ? run_bytes[0] : -1, 'h8D);
      check_int("s3_byte1", run_bytes.size() > 1 ? run_bytes[1] : -1, 'hEB);
      check_int("s3_byte2", run_bytes.size() > 2 ? run_bytes[2] : -1, 'hA7);

      // READY held low for 200 cycles stretches the strobe.
      clear_logs();
      push(0, 7, 2);
      cycles(10);
      READY = 1'b0;
      cycles(200);
      READY = 1'b1;
      wait_idle(600, "s4");
      check_int("s4_runs", runs.size(), 1);
      check_int("s4_len_ge200", (runs.size() > 0 && runs[0] >= 200) ? 1 : 0, 1);
      check_int("s4_len_le215", (runs.size() > 0 && runs[0] <= 215) ? 1 : 0, 1);
      check_int("s4_byte0", run_bytes.size() > 0 ? run_bytes[0] : -1, 'h4F);

      // Reset in the middle of a strobe: aborted, never acknowledged again.
      clear_logs();
      push(1, 4, 3);
      cycles(20);
      do_reset();
      cycles(20);
      check_int("s5_grants", grants.size(), 1);
      check_int("s5_runs", runs.size(), 1);
      check_int("s5_aborted_short", (runs.size() > 0 && runs[0] < 64) ? 1 : 0, 1);
      check_int("s5_busy_after", int'(busy), 0);

      // Same value written twice to a one-byte register.
      clear_logs();
      push(0, 1, 5);
      push(0, 1, 5);
      wait_idle(600, "s6");
      check_int("s6_grants", grants.size(), 2);
`ifdef KF76489_SEQ_SHADOW_EN
      check_int("s6_runs", runs.size(), 1);
`else
      check_int("s6_runs", runs.size(), 2);
`endif
      check_int("s6_byte0", run_bytes.size() > 0 ? run_bytes[0] : -1, 'hA9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
